// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl: readback walker for the sample SRAM ring buffer.
// After a capture completes it reads READ_LEN words ending just before the
// writer's final address, handing one word to the MCU per RD_REQ.
// Optional build macro SRAM_RD_PREFETCH_EN adds a one-word prefetch register
// so that a request is answered on the next edge while the following word is
// fetched in the background.
module sram_read_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int SRAM_WAIT = 1
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              Start_Read,
    input  logic              Stop_Read,
    input  logic              Write_Ready,
    input  logic [ADDR_W-1:0] ADDR_CNT_IN,
    input  logic [ADDR_W-1:0] READ_LEN,
    input  logic              RD_REQ,
    input  logic [DATA_W-1:0] SRAM_DATA_IN,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_OE,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_VALID,
    output logic              Read_Busy,
    output logic              Read_Done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_SETUP    = 3'd2,
        S_WAIT_REQ = 3'd3,
        S_FETCH    = 3'd4,
        S_LATCH    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [2:0]        WAIT_LAST = 3'(SRAM_WAIT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          wait_q, wait_d;
    logic                oe_q, oe_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dv_q, dv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_prev_q;
    logic                start_rise_s;
`ifdef SRAM_RD_PREFETCH_EN
    logic [DATA_W-1:0]   pf_data_q, pf_data_d;
    logic                pend_q, pend_d;
`endif

    assign start_rise_s = Start_Read & ~start_prev_q;

    // Next-state, address/count bookkeeping and output register inputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
`ifdef SRAM_RD_PREFETCH_EN
        pf_data_d = pf_data_q;
        pend_d    = pend_q;
`endif
        if (Stop_Read) begin
            // Abort wins over everything; address and data are left as they are.
            state_d = S_IDLE;
            oe_d    = 1'b1;
`ifdef SRAM_RD_PREFETCH_EN
            pend_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_rise_s) begin
                        state_d = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ARM: begin
                    if (Write_Ready) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_ARM;
                    end
                end
                S_SETUP: begin
                    // Oldest word of the window: borrow discarded gives the ring wrap.
                    addr_d = ADDR_CNT_IN - READ_LEN;
                    cnt_d  = READ_LEN;
`ifdef SRAM_RD_PREFETCH_EN
                    pend_d = 1'b0;
                    if (READ_LEN == ADDR_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        oe_d    = 1'b0;
                        wait_d  = 3'd0;
                    end
`else
                    if (READ_LEN == ADDR_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_REQ;
                    end
`endif
                end
                S_WAIT_REQ: begin
`ifdef SRAM_RD_PREFETCH_EN
                    // Prefetched word is always valid here; serve it at once.
                    if (RD_REQ) begin
                        dout_d = pf_data_q;
                        dv_d   = 1'b1;
                        if (cnt_q == ADDR_ZERO) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            oe_d    = 1'b0;
                            wait_d  = 3'd0;
                        end
                    end else begin
                        state_d = S_WAIT_REQ;
                    end
`else
                    if (RD_REQ) begin
                        state_d = S_FETCH;
                        oe_d    = 1'b0;
                        wait_d  = 3'd0;
                    end else begin
                        state_d = S_WAIT_REQ;
                    end
`endif
                end
                S_FETCH: begin
`ifdef SRAM_RD_PREFETCH_EN
                    if (RD_REQ) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (wait_q == WAIT_LAST) begin
                        addr_d = addr_q + ADDR_ONE;
                        cnt_d  = cnt_q - ADDR_ONE;
                        if (pend_q || RD_REQ) begin
                            // A request is already waiting: hand the word straight over.
                            dout_d = SRAM_DATA_IN;
                            dv_d   = 1'b1;
                            pend_d = 1'b0;
                            if (cnt_q == ADDR_ONE) begin
                                state_d = S_DONE;
                                oe_d    = 1'b1;
                            end else begin
                                state_d = S_FETCH;
                                oe_d    = 1'b0;
                                wait_d  = 3'd0;
                            end
                        end else begin
                            pf_data_d = SRAM_DATA_IN;
                            state_d   = S_WAIT_REQ;
                            oe_d      = 1'b1;
                        end
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
`else
                    if (wait_q == WAIT_LAST) begin
                        // Data is sampled while OE is still low, then OE is released.
                        dout_d  = SRAM_DATA_IN;
                        dv_d    = 1'b1;
                        oe_d    = 1'b1;
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = cnt_q - ADDR_ONE;
                        state_d = S_LATCH;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
`endif
                end
                S_LATCH: begin
                    if (cnt_q == ADDR_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_REQ;
                    end
                end
                S_DONE: begin
                    if (!Start_Read) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b1;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset releases OE without waiting for a clock.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= S_IDLE;
            addr_q       <= ADDR_ZERO;
            cnt_q        <= ADDR_ZERO;
            wait_q       <= 3'd0;
            oe_q         <= 1'b1;
            dout_q       <= {DATA_W{1'b0}};
            dv_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
            dv_q         <= dv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_prev_q <= Start_Read;
        end
    end

`ifdef SRAM_RD_PREFETCH_EN
    // Prefetch word and pending-request flag.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pf_data_q <= {DATA_W{1'b0}};
            pend_q    <= 1'b0;
        end else begin
            pf_data_q <= pf_data_d;
            pend_q    <= pend_d;
        end
    end
`endif

    assign SRAM_ADDR  = addr_q;
    assign SRAM_OE    = oe_q;
    assign DATA_OUT   = dout_q;
    assign DATA_VALID = dv_q;
    assign Read_Busy  = busy_q;
    assign Read_Done  = done_q;

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Self-checking bench for sram_read_ctrl (default build, SRAM_WAIT=1).
// The SRAM is modelled as a function of the address that only drives valid
// data while OE is low.
module tb_sram_read_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          CLK;
    logic          nRESET;
    logic          Start_Read;
    logic          Stop_Read;
    logic          Write_Ready;
    logic [AW-1:0] ADDR_CNT_IN;
    logic [AW-1:0] READ_LEN;
    logic          RD_REQ;
    logic [DW-1:0] SRAM_DATA_IN;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_OE;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_VALID;
    logic          Read_Busy;
    logic          Read_Done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] got_q[$];
    int            oe_low = 0;

    sram_read_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SRAM_WAIT(1)) dut (
        .CLK(CLK), .nRESET(nRESET), .Start_Read(Start_Read), .Stop_Read(Stop_Read),
        .Write_Ready(Write_Ready), .ADDR_CNT_IN(ADDR_CNT_IN), .READ_LEN(READ_LEN),
        .RD_REQ(RD_REQ), .SRAM_DATA_IN(SRAM_DATA_IN), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_OE(SRAM_OE), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .Read_Busy(Read_Busy), .Read_Done(Read_Done)
    );

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'd0};
    endfunction

    assign SRAM_DATA_IN = SRAM_OE ? 16'hDEAD : mem(SRAM_ADDR);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Collect every delivered word and count OE-low cycles.
    always @(negedge CLK) begin
        if (nRESET) begin
            if (DATA_VALID) got_q.push_back(DATA_OUT);
            if (!SRAM_OE) oe_low++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Full readback with a reference list built from the ring-buffer rule.
    task automatic run_read(input logic [AW-1:0] ac, input logic [AW-1:0] len,
                            input bit spur, input int maxgap);
        logic [DW-1:0] expq[$];
        logic [AW-1:0] a;
        int base_w, base_oe, k, n;
        n = int'(len);
        for (int i = 0; i < n; i++) begin
            a = ac - len + AW'(i);
            expq.push_back(mem(a));
        end
        base_w  = got_q.size();
        base_oe = oe_low;
        ADDR_CNT_IN = ac;
        READ_LEN    = len;
        Write_Ready = 1'b1;
        Start_Read  = 1'b1;
        repeat (3) @(negedge CLK);
        if (n == 0) check("len0_done", 32'(Read_Done), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge CLK);
            RD_REQ = 1'b1;
            @(negedge CLK);
            RD_REQ = 1'b0;
            if (spur) begin
                RD_REQ = 1'b1;
                @(negedge CLK);
                RD_REQ = 1'b0;
            end
            k = 0;
            while (!DATA_VALID && k < 20) begin
                @(negedge CLK);
                k++;
            end
            if (!DATA_VALID) begin
                n_checks++;
                n_fail++;
                $display("FAIL dv_timeout: got no DATA_VALID expected word %0d", i);
            end
            @(negedge CLK);
        end
        if (n > 0) begin
            check("done_after_last", 32'(Read_Done), 32'd1);
            check("busy_after_last", 32'(Read_Busy), 32'd0);
        end
        check("word_count", 32'(got_q.size() - base_w), 32'(n));
        for (int i = 0; i < n && base_w + i < got_q.size(); i++)
            check("word_data", 32'(got_q[base_w + i]), 32'(expq[i]));
        check("oe_cycles", 32'(oe_low - base_oe), 32'(n * 2));
        Start_Read = 1'b0;
        repeat (2) @(negedge CLK);
        check("back_idle", 32'(Read_Done), 32'd0);
    endtask

    typedef struct {
        logic [AW-1:0] ac;
        logic [AW-1:0] len;
        logic [DW-1:0] first;
        logic [DW-1:0] last;
        bit            spur;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bw;
        logic [AW-1:0] rac, rlen;
        vecs[0] = '{18'h00100, 18'd4, 16'h00FC, 16'h00FF, 1'b0};
        vecs[1] = '{18'h00002, 18'd4, 16'h3FFE, 16'h0001, 1'b1};
        vecs[2] = '{18'h00005, 18'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{18'h3FFFF, 18'd1, 16'h3FFE, 16'h3FFE, 1'b0};
        vecs[4] = '{18'h00000, 18'd3, 16'h3FFD, 16'h3FFF, 1'b1};
        vecs[5] = '{18'h10000, 18'd2, 16'hFFFE, 16'hFFFF, 1'b0};

        nRESET = 1'b0; Start_Read = 1'b0; Stop_Read = 1'b0; Write_Ready = 1'b0;
        ADDR_CNT_IN = '0; READ_LEN = '0; RD_REQ = 1'b0;
        #12;
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_oe", 32'(SRAM_OE), 32'd1);
        check("rst_dout", 32'(DATA_OUT), 32'd0);
        check("rst_dv", 32'(DATA_VALID), 32'd0);
        check("rst_busy", 32'(Read_Busy), 32'd0);
        check("rst_done", 32'(Read_Done), 32'd0);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        // Table-driven readbacks.
        for (int v = 0; v < 6; v++) begin
            bw = got_q.size();
            run_read(vecs[v].ac, vecs[v].len, vecs[v].spur, 2);
            if (vecs[v].len != 18'd0 && got_q.size() > bw) begin
                check("vec_first", 32'(got_q[bw]), 32'(vecs[v].first));
                check("vec_last", 32'(got_q[got_q.size() - 1]), 32'(vecs[v].last));
            end
        end

        // Latency: OE low for two samples, DATA_VALID on the third; extra request ignored.
        bw = got_q.size();
        ADDR_CNT_IN = 18'h00020; READ_LEN = 18'd1; Write_Ready = 1'b1; Start_Read = 1'b1;
        repeat (3) @(negedge CLK);
        RD_REQ = 1'b1;
        @(negedge CLK);
        check("lat_oe_n1", 32'(SRAM_OE), 32'd0);
        check("lat_dv_n1", 32'(DATA_VALID), 32'd0);
        @(negedge CLK);
        RD_REQ = 1'b0;
        check("lat_oe_n2", 32'(SRAM_OE), 32'd0);
        check("lat_dv_n2", 32'(DATA_VALID), 32'd0);
        @(negedge CLK);
        check("lat_oe_n3", 32'(SRAM_OE), 32'd1);
        check("lat_dv_n3", 32'(DATA_VALID), 32'd1);
        check("lat_data", 32'(DATA_OUT), 32'h001F);
        @(negedge CLK);
        check("lat_dv_off", 32'(DATA_VALID), 32'd0);
        check("lat_done", 32'(Read_Done), 32'd1);
        repeat (4) @(negedge CLK);
        check("lat_one_word", 32'(got_q.size() - bw), 32'd1);
        Start_Read = 1'b0;
        repeat (2) @(negedge CLK);

        // Stop_Read mid-FETCH: idle next cycle, address and data hold, no re-arm.
        ADDR_CNT_IN = 18'h00300; READ_LEN = 18'd3; Start_Read = 1'b1;
        repeat (3) @(negedge CLK);
        RD_REQ = 1'b1;
        @(negedge CLK);
        RD_REQ = 1'b0;
        check("stop_pre_oe", 32'(SRAM_OE), 32'd0);
        Stop_Read = 1'b1;
        @(negedge CLK);
        Stop_Read = 1'b0;
        check("stop_oe", 32'(SRAM_OE), 32'd1);
        check("stop_busy", 32'(Read_Busy), 32'd0);
        check("stop_dv", 32'(DATA_VALID), 32'd0);
        check("stop_addr", 32'(SRAM_ADDR), 32'h002FD);
        check("stop_dout", 32'(DATA_OUT), 32'h001F);
        repeat (3) @(negedge CLK);
        check("stop_no_rearm", 32'(Read_Busy), 32'd0);
        Start_Read = 1'b0;
        @(negedge CLK);

        // ARM waits for Write_Ready; SETUP lasts one cycle.
        Write_Ready = 1'b0; ADDR_CNT_IN = 18'h00010; READ_LEN = 18'd0; Start_Read = 1'b1;
        repeat (51) @(negedge CLK);
        check("arm_busy", 32'(Read_Busy), 32'd1);
        check("arm_done", 32'(Read_Done), 32'd0);
        check("arm_oe", 32'(SRAM_OE), 32'd1);
        Write_Ready = 1'b1;
        @(negedge CLK);
        check("setup_busy", 32'(Read_Busy), 32'd1);
        check("setup_done", 32'(Read_Done), 32'd0);
        @(negedge CLK);
        check("arm_to_done", 32'(Read_Done), 32'd1);
        Start_Read = 1'b0;
        repeat (2) @(negedge CLK);

        // Asynchronous reset mid-FETCH.
        ADDR_CNT_IN = 18'h00400; READ_LEN = 18'd2; Start_Read = 1'b1;
        repeat (3) @(negedge CLK);
        RD_REQ = 1'b1;
        @(negedge CLK);
        RD_REQ = 1'b0;
        check("arst_pre_oe", 32'(SRAM_OE), 32'd0);
        #2;
        nRESET = 1'b0;
        #1;
        check("arst_oe", 32'(SRAM_OE), 32'd1);
        check("arst_addr", 32'(SRAM_ADDR), 32'd0);
        check("arst_dout", 32'(DATA_OUT), 32'd0);
        check("arst_dv", 32'(DATA_VALID), 32'd0);
        check("arst_busy", 32'(Read_Busy), 32'd0);
        check("arst_done", 32'(Read_Done), 32'd0);
        Start_Read = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        // Randomized readbacks against the reference list.
        for (int it = 0; it < 12; it++) begin
            rac  = AW'($urandom);
            if (it % 4 == 0) rac = AW'($urandom_range(0, 3));
            rlen = AW'($urandom_range(0, 6));
            run_read(rac, rlen, bit'($urandom_range(0, 1)), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
